pam4_lane_sched: RTL and testbench

- Round-robin scheduler that shares one PAM-4 voltage-level decoder among NUM_LANES receive lanes.
- Accepts per-lane voltage samples with a valid/ready handshake and issues one sample per cycle to the decoder.
- Carries a lane tag alongside each sample through the decoder's fixed latency.
- Packs the returned 2-bit symbols into per-lane bytes, tagged with lane number, for the Rx-side binary reconstruction path.

---
 rtl/pam4_sched_pkg.sv | 25 ++
 rtl/pam4_rr_arbiter.sv | 53 +++++
 rtl/pam4_lane_sched.sv | 176 +++++++++++++++++
 tb/tb_pam4_lane_sched.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pam4_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pam4_sched_pkg
// Description : Shared constants, lane-width helper and tag type for the
//               PAM-4 lane scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package pam4_sched_pkg;

  localparam int SYMBOLS_PER_BYTE = 4;
  localparam int LANE_TAG_W       = 3;

  typedef logic [LANE_TAG_W-1:0] tag_lane_t;

  typedef struct packed {
    logic      valid;
    tag_lane_t lane;
  } lane_tag_t;

  function automatic int LANE_W(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pam4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pam4_rr_arbiter
// Description : Round-robin one-hot arbiter; pointer moves past the granted
//               requester whenever any request is present.
// Revision    : 1.0 - initial release
// ============================================================================
module pam4_rr_arbiter
  import pam4_sched_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_LANES-1:0]          i_req,
  output logic [NUM_LANES-1:0]          o_grant,
  output logic [LANE_W(NUM_LANES)-1:0]  o_grant_idx,
  output logic                          o_any
);

  localparam int                   LW     = LANE_W(NUM_LANES);
  localparam logic [NUM_LANES-1:0] c_ONE  = NUM_LANES'(1);
  localparam logic [LW-1:0]        c_LAST = LW'(NUM_LANES - 1);

  logic [LW-1:0]        r_ptr;
  logic [NUM_LANES-1:0] w_mask;
  logic [NUM_LANES-1:0] w_hi;
  logic [NUM_LANES-1:0] w_pick;

  // Requests at or above the pointer win; otherwise wrap to the lowest one.
  assign w_mask  = ~((c_ONE << r_ptr) - c_ONE);
  assign w_hi    = i_req & w_mask;
  assign w_pick  = (|w_hi) ? w_hi : i_req;
  assign o_grant = w_pick & (~w_pick + c_ONE);
  assign o_any   = |i_req;

  always_comb begin
    o_grant_idx = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (o_grant[i]) o_grant_idx = LW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ptr <= '0;
    end else if (o_any) begin
      r_ptr <= (o_grant_idx == c_LAST) ? '0 : o_grant_idx + LW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pam4_lane_sched.sv
`default_nettype none
// ============================================================================
// Module      : pam4_lane_sched
// Description : Shares one PAM-4 decoder among NUM_LANES lanes and packs the
//               returned symbols into per-lane bytes. Optional per-lane byte
//               counters under PAM4_LANE_SCHED_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pam4_lane_sched
  import pam4_sched_pkg::*;
#(
  parameter int NUM_LANES         = 4,
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int DEC_LATENCY       = 1
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic [NUM_LANES*SIGNAL_RESOLUTION-1:0] lane_voltage_in,
  input  logic [NUM_LANES-1:0]                   lane_valid_in,
  output logic [NUM_LANES-1:0]                   lane_ready_out,
  input  logic                                   flush_in,
  output logic [SIGNAL_RESOLUTION-1:0]           dec_voltage_out,
  output logic                                   dec_valid_out,
  input  logic [1:0]                             dec_symbol_in,
  input  logic                                   dec_symbol_valid_in,
  output logic [7:0]                             byte_out,
  output logic [LANE_W(NUM_LANES)-1:0]           byte_lane_out,
  output logic                                   byte_valid_out,
`ifdef PAM4_LANE_SCHED_STATS_EN
  input  logic [LANE_W(NUM_LANES)-1:0]           stat_lane_sel,
  output logic [15:0]                            stat_byte_cnt,
`endif
  output logic                                   tag_err_out
);

  localparam int LW = LANE_W(NUM_LANES);

  logic [NUM_LANES-1:0]         w_grant;
  logic [LW-1:0]                w_idx;
  logic                         w_any;
  logic [SIGNAL_RESOLUTION-1:0] w_sample;

  logic [SIGNAL_RESOLUTION-1:0] r_dec_voltage;
  logic                         r_dec_valid;
  logic [LW-1:0]                r_issue_lane;
  lane_tag_t                    r_tag [DEC_LATENCY];
  lane_tag_t                    w_head;
  logic [LW-1:0]                w_lane;
  logic                         w_tag_unused;
  logic                         w_sym_ok;
  logic [7:0]                   w_new_byte;

  logic [7:0]                   r_sr  [NUM_LANES];
  logic [1:0]                   r_cnt [NUM_LANES];
  logic                         r_pend;
  logic [7:0]                   r_pend_byte;
  logic [LW-1:0]                r_pend_lane;
  logic [7:0]                   r_byte;
  logic [LW-1:0]                r_byte_lane;
  logic                         r_byte_valid;
  logic                         r_tag_err;

  pam4_rr_arbiter #(.NUM_LANES(NUM_LANES)) u_arb (
    .clk         (clk),
    .rstn        (rstn),
    .i_req       (lane_valid_in),
    .o_grant     (w_grant),
    .o_grant_idx (w_idx),
    .o_any       (w_any)
  );

  assign lane_ready_out = rstn ? w_grant : '0;

  always_comb begin
    w_sample = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_grant[i]) w_sample = lane_voltage_in[i*SIGNAL_RESOLUTION +: SIGNAL_RESOLUTION];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_dec_voltage <= '0;
      r_dec_valid   <= 1'b0;
      r_issue_lane  <= '0;
    end else begin
      r_dec_valid <= w_any;
      if (w_any) begin
        r_dec_voltage <= w_sample;
        r_issue_lane  <= w_idx;
      end
    end
  end

  // Tags travel alongside the decoder so the head lines up with its symbol.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEC_LATENCY; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= '{valid: r_dec_valid, lane: tag_lane_t'(r_issue_lane)};
      for (int i = 1; i < DEC_LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign w_head       = r_tag[DEC_LATENCY-1];
  assign w_lane       = w_head.lane[LW-1:0];
  assign w_tag_unused = ^w_head.lane;
  assign w_sym_ok     = dec_symbol_valid_in & w_head.valid & ~flush_in;
  assign w_new_byte   = {r_sr[w_lane][5:0], dec_symbol_in};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        r_sr[i]  <= '0;
        r_cnt[i] <= '0;
      end
      r_pend      <= 1'b0;
      r_pend_byte <= '0;
      r_pend_lane <= '0;
      r_tag_err   <= 1'b0;
    end else begin
      r_pend <= 1'b0;
      if (dec_symbol_valid_in && !w_head.valid) r_tag_err <= 1'b1;
      if (flush_in) begin
        for (int i = 0; i < NUM_LANES; i++) r_cnt[i] <= '0;
      end else if (w_sym_ok) begin
        r_sr[w_lane] <= w_new_byte;
        if (r_cnt[w_lane] == 2'(SYMBOLS_PER_BYTE - 1)) begin
          r_cnt[w_lane] <= '0;
          r_pend        <= 1'b1;
          r_pend_byte   <= w_new_byte;
          r_pend_lane   <= w_lane;
        end else begin
          r_cnt[w_lane] <= r_cnt[w_lane] + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_byte       <= '0;
      r_byte_lane  <= '0;
      r_byte_valid <= 1'b0;
    end else begin
      r_byte_valid <= r_pend;
      if (r_pend) begin
        r_byte      <= r_pend_byte;
        r_byte_lane <= r_pend_lane;
      end
    end
  end

`ifdef PAM4_LANE_SCHED_STATS_EN
  logic [15:0] r_stat [NUM_LANES];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_LANES; i++) r_stat[i] <= '0;
    end else if (r_pend && (r_stat[r_pend_lane] != 16'hFFFF)) begin
      r_stat[r_pend_lane] <= r_stat[r_pend_lane] + 16'd1;
    end
  end

  assign stat_byte_cnt = (int'(stat_lane_sel) < NUM_LANES) ? r_stat[stat_lane_sel] : 16'd0;
`endif

  assign dec_voltage_out = r_dec_voltage;
  assign dec_valid_out   = r_dec_valid;
  assign byte_out        = r_byte;
  assign byte_lane_out   = r_byte_lane;
  assign byte_valid_out  = r_byte_valid;
  assign tag_err_out     = r_tag_err;

endmodule
`default_nettype wire

// File: tb/tb_pam4_lane_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_pam4_lane_sched
// Description : Directed and random checks of pam4_lane_sched against a
//               transaction-level model with a one-cycle decoder stand-in.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pam4_lane_sched;

  localparam int N  = 4;
  localparam int SR = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N*SR-1:0] volt;
  logic [N-1:0]  valid;
  logic [N-1:0]  ready;
  logic          flush;
  logic [SR-1:0] dec_v;
  logic          dec_vld;
  logic [1:0]    dsym;
  logic          dsv;
  logic          force_sv;
  logic          sym_vld;
  logic [7:0]    byte_o;
  logic [1:0]    lane_o;
  logic          bvalid;
  logic          tag_err;

  pam4_lane_sched #(.NUM_LANES(N), .SIGNAL_RESOLUTION(SR), .DEC_LATENCY(1)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .lane_voltage_in     (volt),
    .lane_valid_in       (valid),
    .lane_ready_out      (ready),
    .flush_in            (flush),
    .dec_voltage_out     (dec_v),
    .dec_valid_out       (dec_vld),
    .dec_symbol_in       (dsym),
    .dec_symbol_valid_in (sym_vld),
    .byte_out            (byte_o),
    .byte_lane_out       (lane_o),
    .byte_valid_out      (bvalid),
    .tag_err_out         (tag_err)
  );

  always #5 clk = ~clk;

  function automatic int sym_of(input logic [7:0] v);
    case (v)
      8'hAC:   return 0;
      8'hE4:   return 1;
      8'h1C:   return 2;
      8'h54:   return 3;
      default: return 0;
    endcase
  endfunction

  // Decoder stand-in: one cycle from voltage valid to symbol valid.
  always @(posedge clk) begin
    if (!rstn) begin
      dsv  <= 1'b0;
      dsym <= 2'd0;
    end else begin
      dsv  <= dec_vld;
      dsym <= 2'(sym_of(dec_v));
    end
  end
  assign sym_vld = dsv | force_sv;

  typedef struct { int e; int lane; int sym; } acc_t;
  typedef struct { int due; int lane; int b; } exp_t;

  acc_t       accq[$];
  exp_t       expq[$];
  int         m_syms[N][$];
  int         m_ptr;
  logic       m_dv;
  logic [7:0] m_volt;
  logic       m_err;
  int         edge_n;
  int         tests;
  int         fails;
  int         nbytes;
  logic [7:0] last_b;
  logic [1:0] last_l;
  logic [7:0] codes [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_clear();
    accq.delete();
    expq.delete();
    for (int l = 0; l < N; l++) m_syms[l].delete();
    m_ptr  = 0;
    m_dv   = 1'b0;
    m_volt = 8'h00;
    m_err  = 1'b0;
  endtask

  task automatic step();
    int g;
    logic [N-1:0] exp_rdy;
    logic fl, fv, rs, arrived;
    acc_t a;
    exp_t e;
    int b;
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    exp_rdy = '0;
    if (rstn && g >= 0) exp_rdy[g] = 1'b1;
    chk("lane_ready", 32'(ready), 32'(exp_rdy));
    fl = flush; fv = force_sv; rs = rstn;
    if (rstn && g >= 0) begin
      accq.push_back('{edge_n + 1, g, sym_of(volt[g*SR +: SR])});
      m_ptr  = (g + 1) % N;
      m_dv   = 1'b1;
      m_volt = volt[g*SR +: SR];
    end else begin
      m_dv = 1'b0;
    end
    @(posedge clk);
    edge_n++;
    if (!rs) begin
      model_clear();
    end else begin
      arrived = (accq.size() > 0) && (accq[0].e == edge_n - 2);
      if (arrived) a = accq.pop_front();
      if (fv && !arrived) m_err = 1'b1;
      if (fl) begin
        for (int l = 0; l < N; l++) m_syms[l].delete();
      end else if (arrived) begin
        m_syms[a.lane].push_back(a.sym);
        if (m_syms[a.lane].size() == 4) begin
          b = m_syms[a.lane][0]*64 + m_syms[a.lane][1]*16 + m_syms[a.lane][2]*4 + m_syms[a.lane][3];
          expq.push_back('{edge_n + 1, a.lane, b});
          m_syms[a.lane].delete();
        end
      end
    end
    #1;
    chk("dec_valid", 32'(dec_vld), 32'(m_dv));
    chk("dec_voltage", 32'(dec_v), 32'(m_volt));
    chk("tag_err", 32'(tag_err), 32'(m_err));
    if (expq.size() > 0 && expq[0].due == edge_n) begin
      e = expq.pop_front();
      chk("byte_valid", 32'(bvalid), 32'd1);
      chk("byte_out", 32'(byte_o), 32'(e.b));
      chk("byte_lane", 32'(lane_o), 32'(e.lane));
      last_b = byte_o;
      last_l = lane_o;
      nbytes++;
    end else begin
      chk("byte_idle", 32'(bvalid), 32'd0);
    end
  endtask

  task automatic idle(input int n);
    valid = '0;
    flush = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input int lane, input logic [7:0] v);
    valid = '0;
    valid[lane] = 1'b1;
    volt[lane*SR +: SR] = v;
    step();
  endtask

  initial begin
    int nb0;
    codes[0] = 8'hAC; codes[1] = 8'hE4; codes[2] = 8'h1C; codes[3] = 8'h54;
    tests = 0; fails = 0; nbytes = 0; edge_n = 0;
    last_b = 8'h00; last_l = 2'd0;
    model_clear();
    rstn = 1'b0; flush = 1'b0; force_sv = 1'b0;
    valid = '1; volt = '0;

    // Reset: grants suppressed even with every lane requesting.
    repeat (3) step();
    chk("rst_byte_out", 32'(byte_o), 32'd0);
    chk("rst_byte_lane", 32'(lane_o), 32'd0);
    chk("rst_tag_err", 32'(tag_err), 32'd0);
    rstn = 1'b1;
    idle(2);

    // Lane 0 alone, one of each symbol.
    nb0 = nbytes;
    send(0, 8'hAC); send(0, 8'hE4); send(0, 8'h1C); send(0, 8'h54);
    idle(4);
    chk("t1_count", 32'(nbytes - nb0), 32'd1);
    chk("t1_byte", 32'(last_b), 32'h1B);
    chk("t1_lane", 32'(last_l), 32'd0);

    // All lanes busy with 0x54: one 0xFF per lane.
    nb0 = nbytes;
    volt = {4{8'h54}};
    valid = '1;
    repeat (16) step();
    idle(4);
    chk("t2_count", 32'(nbytes - nb0), 32'd4);
    chk("t2_byte", 32'(last_b), 32'hFF);

    // Move pointer to 2, then lanes 1 and 3 contend.
    send(1, 8'hAC);
    valid = 4'b1010;
    repeat (6) step();
    idle(4);

    // Two symbols on lane 2, flush, then four 0xE4.
    send(2, 8'h1C); send(2, 8'h1C);
    idle(4);
    flush = 1'b1; step(); flush = 1'b0;
    nb0 = nbytes;
    repeat (4) send(2, 8'hE4);
    idle(4);
    chk("t4_count", 32'(nbytes - nb0), 32'd1);
    chk("t4_byte", 32'(last_b), 32'h55);
    chk("t4_lane", 32'(last_l), 32'd2);

    // Symbol with no tag in flight.
    nb0 = nbytes;
    idle(3);
    force_sv = 1'b1; step(); force_sv = 1'b0;
    idle(4);
    chk("t5_tag_err", 32'(tag_err), 32'd1);
    chk("t5_no_byte", 32'(nbytes - nb0), 32'd0);

    // Random traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      valid = N'($urandom_range(0, (1 << N) - 1));
      for (int l = 0; l < N; l++) volt[l*SR +: SR] = codes[$urandom_range(0, 3)];
      flush = ($urandom_range(0, 19) == 0);
      step();
    end
    idle(4);

    // Reset with samples in flight, then a clean byte.
    send(0, 8'h54); send(0, 8'h54); send(0, 8'h54);
    valid = '0; rstn = 1'b0;
    step(); step();
    rstn = 1'b1;
    nb0 = nbytes;
    idle(4);
    chk("t6_no_byte", 32'(nbytes - nb0), 32'd0);
    chk("t6_tag_err", 32'(tag_err), 32'd0);
    send(0, 8'hE4); send(0, 8'hAC); send(0, 8'h54); send(0, 8'h1C);
    idle(4);
    chk("t6_count", 32'(nbytes - nb0), 32'd1);
    chk("t6_byte", 32'(last_b), 32'h4E);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
